// File: rtl/stdcore_2p_rf.sv
// stdcore_2p_rf: two-port register file with read-before-write collision semantics and a registered read port
module stdcore_2p_rf #(
  parameter int DW = 1,
  parameter int AW = 1,
  parameter int DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] waddr,
  input  logic          we_n,
  input  logic [AW-1:0] raddr,
  input  logic          re_n,
  output logic [DW-1:0] rdata
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);
  logic [DW-1:0] mem [DEPTH];
  logic          w_ok, r_ok;
  logic [IW-1:0] wi, ri;
  assign w_ok = {1'b0, waddr} < LIMIT;
  assign r_ok = {1'b0, raddr} < LIMIT;
  assign wi = IW'(waddr);
  assign ri = IW'(raddr);
  // storage is deliberately not reset; only in-range writes land
  always_ff @(posedge clk)
    if (!rst && !we_n && w_ok) mem[wi] <= wdata;
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (!re_n) rdata <= r_ok ? mem[ri] : '0;
endmodule

// File: tb/tb_stdcore_2p_rf.sv
// tb_stdcore_2p_rf: scoreboard bench driving a full-depth and a partial-depth instance with shared stimulus
module tb_stdcore_2p_rf;
  logic       clk = 0, rst = 1, we_n = 1, re_n = 1;
  logic [7:0] wdata = 0, rdata16, rdata12;
  logic [3:0] waddr = 0, raddr = 0;
  always #5 clk = ~clk;

  stdcore_2p_rf #(.DW(8), .AW(4), .DEPTH(16)) dut16 (
    .clk(clk), .rst(rst), .wdata(wdata), .waddr(waddr), .we_n(we_n),
    .raddr(raddr), .re_n(re_n), .rdata(rdata16));
  stdcore_2p_rf #(.DW(8), .AW(4), .DEPTH(12)) dut12 (
    .clk(clk), .rst(rst), .wdata(wdata), .waddr(waddr), .we_n(we_n),
    .raddr(raddr), .re_n(re_n), .rdata(rdata12));

  typedef struct packed {logic [7:0] d; logic k;} exp_t;
  exp_t q16[$], q12[$];
  exp_t last16 = '{d: 8'h0, k: 1'b0}, last12 = '{d: 8'h0, k: 1'b0};
  exp_t e, f;
  logic [7:0] m16 [16], m12 [12];
  bit v16 [16], v12 [12];
  int checks = 0, errors = 0;

  // model: read-before-write, hold when idle, out-of-range reads give 0
  task automatic step(input bit r, input bit wn, input logic [3:0] wa, input logic [7:0] wd,
                      input bit rn, input logic [3:0] ra);
    rst = r; we_n = wn; waddr = wa; wdata = wd; re_n = rn; raddr = ra;
    if (r) begin
      last16 = '{d: 8'h0, k: 1'b1};
      last12 = '{d: 8'h0, k: 1'b1};
    end else if (!rn) begin
      last16 = '{d: m16[ra], k: v16[ra]};
      last12 = (ra < 12) ? '{d: m12[ra], k: v12[ra]} : '{d: 8'h0, k: 1'b1};
    end
    q16.push_back(last16);
    q12.push_back(last12);
    if (!r && !wn) begin
      m16[wa] = wd; v16[wa] = 1;
      if (wa < 12) begin m12[wa] = wd; v12[wa] = 1; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pop();
    e = q16.pop_front();
    f = q12.pop_front();
  endtask

  task automatic test_reset();
    step(1, 1, 0, 0, 1, 0); pop();
    step(1, 1, 0, 0, 1, 0); pop();
    step(0, 0, 0, 8'h0A, 1, 0); pop();
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 0, 8'h05, 0, 0); pop();
      checks++;
      if (rdata16 !== e.d || rdata16 !== 8'h00) begin
        errors++; $display("FAIL reset_rdata: got %h expected %h", rdata16, e.d);
      end
    end
    step(0, 1, 0, 0, 0, 0); pop();
    checks++;
    if (rdata16 !== e.d || rdata16 !== 8'h0A) begin
      errors++; $display("FAIL reset_blocks_write: got %h expected %h", rdata16, e.d);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin step(0, 0, 4'(i), 8'(i + 'h10), 1, 0); pop(); end
    for (int i = 0; i < 16; i++) begin
      step(0, 1, 0, 0, 0, 4'(i)); pop();
      checks++;
      if (rdata16 !== e.d || rdata16 !== 8'(i + 'h10)) begin
        errors++; $display("FAIL fill_read[%0d]: got %h expected %h", i, rdata16, e.d);
      end
    end
  endtask

  task automatic test_hold();
    step(0, 1, 0, 0, 0, 3); pop();
    checks++;
    if (rdata16 !== 8'h13) begin errors++; $display("FAIL hold_read: got %h expected 13", rdata16); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 3, 8'hFF, 1, 0); pop();
      checks++;
      if (rdata16 !== e.d || rdata16 !== 8'h13) begin
        errors++; $display("FAIL hold_idle[%0d]: got %h expected %h", i, rdata16, e.d);
      end
    end
    step(0, 1, 0, 0, 0, 3); pop();
    checks++;
    if (rdata16 !== e.d || rdata16 !== 8'hFF) begin
      errors++; $display("FAIL hold_reread: got %h expected %h", rdata16, e.d);
    end
  endtask

  task automatic test_collision();
    step(0, 0, 7, 8'h77, 0, 7); pop();
    checks++;
    if (rdata16 !== e.d || rdata16 !== 8'h17) begin
      errors++; $display("FAIL collision_old: got %h expected %h", rdata16, e.d);
    end
    step(0, 1, 0, 0, 0, 7); pop();
    checks++;
    if (rdata16 !== e.d || rdata16 !== 8'h77) begin
      errors++; $display("FAIL collision_new: got %h expected %h", rdata16, e.d);
    end
  endtask

  task automatic test_out_of_range();
    step(0, 0, 13, 8'hAA, 1, 0); pop();
    step(0, 1, 0, 0, 0, 13); pop();
    checks++;
    if (rdata12 !== e.d && rdata12 !== 8'h00 || rdata12 !== f.d) begin
      errors++; $display("FAIL oor_read: got %h expected %h", rdata12, f.d);
    end
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0, 0, 0, 4'(i)); pop();
      if (f.k) begin
        checks++;
        if (rdata12 !== f.d) begin
          errors++; $display("FAIL oor_contents[%0d]: got %h expected %h", i, rdata12, f.d);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1000; n++) begin
      step(0, 1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom), 4'($urandom)); pop();
      if (e.k) begin
        checks++;
        if (rdata16 !== e.d) begin
          errors++; $display("FAIL random16[%0d]: got %h expected %h", n, rdata16, e.d);
        end
      end
      if (f.k) begin
        checks++;
        if (rdata12 !== f.d) begin
          errors++; $display("FAIL random12[%0d]: got %h expected %h", n, rdata12, f.d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hold();
    test_collision();
    test_out_of_range();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
